sensor_seq_gen: RTL and testbench

- Stimulus generator for the parking-lot barrier.
- Takes a single entry or exit command and drives the two-bit photo-sensor bus {a, b} through the physical passage sequence of one car, holding each phase for a programmable number of cycles.
- Sits in front of the entrance/exit detection FSM as its sensor source, for board-level demos and closed-loop benches.
- Reports completion with one-cycle pulses named after the event it generated.

---
 rtl/sensor_seq_gen_if.sv | 43 ++++
 rtl/sensor_seq_gen.sv | 122 ++++++++++++
 tb/tb_sensor_seq_gen.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sensor_seq_gen_if.sv
// Command/sensor bus between a command source (master) and sensor_seq_gen (slave).
// SEQ_ABORT_EN adds the abort strobe and the aborted completion pulse.
interface sensor_seq_gen_if;
  logic       start;
  logic       dir;
  logic [1:0] sensor;
  logic       ready;
  logic       busy;
  logic       done_in;
  logic       done_out;
`ifdef SEQ_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  modport master (
    output start,
    output dir,
`ifdef SEQ_ABORT_EN
    output abort,
    input  aborted,
`endif
    input  sensor,
    input  ready,
    input  busy,
    input  done_in,
    input  done_out
  );

  modport slave (
    input  start,
    input  dir,
`ifdef SEQ_ABORT_EN
    input  abort,
    output aborted,
`endif
    output sensor,
    output ready,
    output busy,
    output done_in,
    output done_out
  );
endinterface

// File: rtl/sensor_seq_gen.sv
// Drives the {a,b} photo-sensor bus through one car passage (entry or exit) per command.
// Optional feature macro: SEQ_ABORT_EN (abort input / aborted pulse).
module sensor_seq_gen #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             reset,
  sensor_seq_gen_if.slave  seq_if
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic [1:0]      sensor_q, sensor_d;
  logic            doneIn_q, doneIn_d;
  logic            doneOut_q, doneOut_d;
  logic            aborted_q, aborted_d;
  logic            abortHit;

  // Entry blocks beam a first, exit blocks beam b first; one bit flips per boundary.
  function automatic logic [1:0] phasePattern(input state_e s, input logic entry);
    case (s)
      PH1:     phasePattern = entry ? 2'b10 : 2'b01;
      PH2:     phasePattern = 2'b11;
      PH3:     phasePattern = entry ? 2'b01 : 2'b10;
      default: phasePattern = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      sensor_q  <= 2'b00;
      doneIn_q  <= 1'b0;
      doneOut_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      sensor_q  <= sensor_d;
      doneIn_q  <= doneIn_d;
      doneOut_q <= doneOut_d;
      aborted_q <= aborted_d;
    end
  end

  // The counter holds cycles remaining minus one; zero marks the last cycle of a state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    abortHit = 1'b0;
    case (state_q)
      IDLE: begin
        if (seq_if.start) begin
          state_d = PH1;
          cnt_d   = HOLD_LOAD;
          dir_d   = seq_if.dir;
        end
      end
      PH1, PH2, PH3: begin
`ifdef SEQ_ABORT_EN
        if (seq_if.abort) begin
          state_d  = GAP;
          cnt_d    = GAP_LOAD;
          abortHit = 1'b1;
        end else
`endif
        if (cnt_q == '0) begin
          case (state_q)
            PH1:     begin state_d = PH2; cnt_d = HOLD_LOAD; end
            PH2:     begin state_d = PH3; cnt_d = HOLD_LOAD; end
            default: begin state_d = GAP; cnt_d = GAP_LOAD;  end
          endcase
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    sensor_d  = phasePattern(state_d, dir_d);
    doneIn_d  = (state_q == PH3) && (state_d == GAP) && !abortHit && dir_q;
    doneOut_d = (state_q == PH3) && (state_d == GAP) && !abortHit && !dir_q;
    aborted_d = abortHit;
  end

  assign seq_if.sensor   = sensor_q;
  assign seq_if.ready    = (state_q == IDLE);
  assign seq_if.busy     = (state_q != IDLE);
  assign seq_if.done_in  = doneIn_q;
  assign seq_if.done_out = doneOut_q;
`ifdef SEQ_ABORT_EN
  assign seq_if.aborted  = aborted_q;
`else
  logic unusedAborted;
  assign unusedAborted = aborted_q;
`endif

endmodule

// File: tb/tb_sensor_seq_gen.sv
// Self-checking bench for sensor_seq_gen: directed passages plus random commands
// compared each cycle against an elapsed-time model of one car passage.
module tb_sensor_seq_gen;

  localparam int H = 4;
  localparam int G = 2;
`ifdef SEQ_ABORT_EN
  localparam bit ABORT_BUILD = 1'b1;
`else
  localparam bit ABORT_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   passCount  = 0;

  // Model: whether a command is in flight, cycles since acceptance, its direction.
  bit mActive  = 1'b0;
  int mElapsed = 0;
  bit mDir     = 1'b0;
  bit mAborted = 1'b0;

  always #5 clk = ~clk;

  sensor_seq_gen_if bus ();

  sensor_seq_gen #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .seq_if (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  task automatic checkModel();
    logic [1:0] expSensor;
    bit         expFinish;
    expSensor = 2'b00;
    if (mActive) begin
      if (mElapsed < H)          expSensor = mDir ? 2'b10 : 2'b01;
      else if (mElapsed < 2*H)   expSensor = 2'b11;
      else if (mElapsed < 3*H)   expSensor = mDir ? 2'b01 : 2'b10;
    end
    expFinish = mActive && (mElapsed == 3*H);
    checkOutput("sensor",   32'(bus.sensor),   32'(expSensor));
    checkOutput("ready",    32'(bus.ready),    32'(!mActive));
    checkOutput("busy",     32'(bus.busy),     32'(mActive));
    checkOutput("done_in",  32'(bus.done_in),  32'(expFinish && !mAborted && mDir));
    checkOutput("done_out", 32'(bus.done_out), 32'(expFinish && !mAborted && !mDir));
`ifdef SEQ_ABORT_EN
    checkOutput("aborted",  32'(bus.aborted),  32'(expFinish && mAborted));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic applyStimulus(input bit s, input bit d, input bit a);
    bus.start = s;
    bus.dir   = d;
`ifdef SEQ_ABORT_EN
    bus.abort = a;
`endif
    @(posedge clk);
    if (!mActive) begin
      if (s) begin
        mActive  = 1'b1;
        mElapsed = 0;
        mDir     = d;
        mAborted = 1'b0;
      end
    end else if (ABORT_BUILD && a && mElapsed < 3*H) begin
      mElapsed = 3*H;
      mAborted = 1'b1;
    end else begin
      mElapsed++;
      if (mElapsed == 3*H + G) mActive = 1'b0;
    end
    #1;
    checkModel();
  endtask

  initial begin
    int doneCount;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.dir   = 1'b0;
`ifdef SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    #3;
    checkOutput("resetSensor", 32'(bus.sensor), 32'd0);
    checkOutput("resetReady",  32'(bus.ready),  32'd1);
    #20 reset = 1'b0;

    // Quiet idle after reset
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0);

    // Entry then exit passages, back to back at the earliest accept point
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3*H + G; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3*H + G + 2; i++) applyStimulus(1'b0, 1'b1, 1'b0);

    // start with dir=0 while busy must be ignored
    doneCount = 0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 3*H + G + 2; i++) begin
      applyStimulus(i == 5, 1'b0, 1'b0);
      if (bus.done_in === 1'b1) doneCount++;
    end
    checkOutput("ignoredStartDoneIn", 32'(doneCount), 32'd1);

    // Asynchronous reset in the middle of PH2
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < H + 1; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("preResetSensor", 32'(bus.sensor), 32'b11);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncResetSensor", 32'(bus.sensor), 32'd0);
    checkOutput("asyncResetReady",  32'(bus.ready),  32'd1);
    checkOutput("asyncResetBusy",   32'(bus.busy),   32'd0);
    mActive = 1'b0;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0);

`ifdef SEQ_ABORT_EN
    // Abort during PH2 of an entry
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < H + 1; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abortAbortedPulse", 32'(bus.aborted), 32'd1);
    for (int i = 0; i < G + 2; i++) applyStimulus(1'b0, 1'b0, 1'b0);
`endif

    // Random commands, with abort strobes in the abort build
    for (int i = 0; i < 800; i++)
      applyStimulus(($urandom_range(3) == 0), 1'($urandom), ($urandom_range(15) == 0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
